// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared types and constants for the program loader
package program_loader_pkg;

    typedef enum logic [1:0] {
        LEN,
        DATA,
        CSUM,
        DONE
    } state_t;

    localparam int ADDR_W_DEF = 4;
    localparam int LEN_MAX    = 1 << ADDR_W_DEF;
    localparam int CSUM_W     = 8;

    function automatic int len_max(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: valid/ready byte stream feeding the program loader
interface program_loader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/program_loader.sv
// program_loader: writes a length-prefixed byte stream into memory and holds the CPU until done
// Optional trailing checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    program_loader_if.slave   s,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int LMAX = len_max(ADDR_W);

    state_t          state;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] l;
    logic [ADDR_W:0] count_nx;
    logic            xfer;
    logic            bad_len;

    assign s.in_ready = ~RST & (state != DONE);
    assign xfer       = s.in_valid & s.in_ready;
    assign l          = s.in_data[ADDR_W:0];
    assign bad_len    = (l == '0) || (int'(l) > LMAX);
    assign count_nx   = count + {{ADDR_W{1'b0}}, 1'b1};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] sum;
    logic [CSUM_W-1:0] sum_nx;

    assign sum_nx = sum + s.in_data;
`endif

    // Loader FSM with registered write port and status outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= LEN;
            len       <= '0;
            count     <= '0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            mem_write <= 1'b0;
            case (state)
                LEN: if (xfer) begin
                    if (bad_len) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        len   <= l;
                        count <= '0;
                        state <= DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum   <= s.in_data;
`endif
                    end
                end
                DATA: if (xfer) begin
                    mem_write <= 1'b1;
                    mem_addr  <= count[ADDR_W-1:0];
                    mem_data  <= s.in_data;
                    count     <= count_nx;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum       <= sum_nx;
                    if (count_nx == len) state <= CSUM;
`else
                    if (count_nx == len) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
`endif
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                CSUM: if (xfer) begin
                    done     <= 1'b1;
                    err      <= |sum_nx;
                    cpu_hold <= |sum_nx;
                    state    <= DONE;
                end
`endif
                DONE: if (start) begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    count    <= '0;
                    cpu_hold <= 1'b1;
                    state    <= LEN;
                end
                default: state <= LEN;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader against a stream-level model
module tb_program_loader;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_write;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   count;

    program_loader_if #(.DATA_W(DW)) s ();

    program_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .s         (s),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_write (mem_write),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    int         n_vec = 0;
    int         n_bad = 0;
    int         wr_cnt = 0;
    logic [7:0] tb_mem [16];
    logic [7:0] exp_mem [16];
    logic [11:0] exp_wr [$];
    logic [11:0] e;
    logic [7:0] q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model and write-order scoreboard
    always @(posedge CLK) begin
        if (!RST && mem_write === 1'b1) begin
            wr_cnt++;
            tb_mem[mem_addr] = mem_data;
            if (exp_wr.size() == 0) check("spurious_wr", 1, 0);
            else begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[11:8]));
                check("wr_data", 32'(mem_data), 32'(e[7:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int g;
        g = (gap < 0) ? $urandom_range(0, 2) : gap;
        repeat (g) begin
            s.in_valid = 1'b0;
            @(posedge CLK); #1;
        end
        s.in_data  = b;
        s.in_valid = 1'b1;
        @(posedge CLK); #1;
        s.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int i = 0;
        while (done !== 1'b1 && i < 64) begin
            @(posedge CLK); #1;
            i++;
        end
        check("done_seen", 32'(done), 1);
    endtask

    task automatic restart();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("start_done", 32'(done), 0);
        check("start_hold", 32'(cpu_hold), 1);
        check("start_count", 32'(count), 0);
        check("start_err", 32'(err), 0);
        check("start_rdy", 32'(s.in_ready), 1);
    endtask

    task automatic load(input logic [7:0] bq [$], input int gap, input int cs_delta);
        int         L;
        logic       bad;
        logic       exp_err;
        logic [7:0] sum;
        logic [7:0] hdr;
        hdr = bq[0];
        L   = int'(hdr[4:0]);
        bad = (L == 0) || (L > 16);
        wr_cnt = 0;
        send(hdr, gap);
        exp_err = bad;
        if (!bad) begin
            check("hold_loading", 32'(cpu_hold), 1);
            sum = hdr;
            for (int k = 1; k <= L; k++) begin
                exp_wr.push_back({4'(k - 1), bq[k]});
                exp_mem[k - 1] = bq[k];
                sum += bq[k];
                send(bq[k], gap);
                check("count_step", 32'(count), k);
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            send(8'(cs_delta) - sum, gap);
            exp_err = (cs_delta % 256) != 0;
`else
            exp_err = (cs_delta < 0);
`endif
        end
        wait_done();
        check("err", 32'(err), 32'(exp_err));
        check("hold", 32'(cpu_hold), 32'(exp_err));
        check("count", 32'(count), bad ? 0 : L);
        check("rdy_done", 32'(s.in_ready), 0);
        @(posedge CLK); #1;
        check("wr_idle", 32'(mem_write), 0);
        check("done_hold", 32'(done), 1);
        check("writes", wr_cnt, bad ? 0 : L);
        check("pending", exp_wr.size(), 0);
        for (int i = 0; i < 16; i++) check("mem", 32'(tb_mem[i]), 32'(exp_mem[i]));
    endtask

    task automatic check_reset_values();
        check("r_wr", 32'(mem_write), 0);
        check("r_addr", 32'(mem_addr), 0);
        check("r_data", 32'(mem_data), 0);
        check("r_hold", 32'(cpu_hold), 1);
        check("r_done", 32'(done), 0);
        check("r_err", 32'(err), 0);
        check("r_count", 32'(count), 0);
        check("r_rdy", 32'(s.in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d1;
        logic [7:0] d2;
        int         r;
        int         ln;
        s.in_valid = 1'b0;
        s.in_data  = '0;
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]  = 8'h00;
            exp_mem[i] = 8'h00;
        end
        repeat (3) @(posedge CLK);
        #1;
        check("rdy_in_reset", 32'(s.in_ready), 0);
        RST = 1'b0;
        #1;
        check_reset_values();

        q = {8'h03, 8'hA1, 8'hB2, 8'hC3};
        load(q, 0, 0);

        restart();
        q = {8'h00};
        load(q, 0, 0);
        restart();
        q = {8'h11};
        load(q, 0, 0);

        restart();
        q = {8'h10};
        for (int k = 0; k < 16; k++) q.push_back(8'($urandom));
        load(q, 1, 0);

        restart();
        d1 = exp_mem[1];
        d2 = ~exp_mem[2];
        send(8'h04, 0);
        q = {8'($urandom)};
        exp_wr.push_back({4'd0, q[0]});
        exp_mem[0] = q[0];
        send(q[0], 0);
        send(d1, 0);
        RST = 1'b1;
        s.in_data  = d2;
        s.in_valid = 1'b1;
        #1;
        check("rdy_rst_mid", 32'(s.in_ready), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        s.in_valid = 1'b0;
        #1;
        check_reset_values();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_pending", exp_wr.size(), 0);
        check("rst_no_wr2", 32'(tb_mem[2]), 32'(exp_mem[2]));
        check("rst_idle_done", 32'(done), 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        q = {8'h02, 8'h10, 8'h20};
        load(q, 0, 0);
        restart();
        load(q, 0, 1);
        restart();
`endif

        q = {8'h01, 8'h55};
        load(q, 0, 0);

        repeat (12) begin
            restart();
            if ($urandom_range(0, 4) == 0) begin
                r  = $urandom_range(16, 31);
                ln = (r == 16) ? 0 : r;
            end else ln = $urandom_range(1, 16);
            q = {{3'($urandom_range(0, 7)), 5'(ln)}};
            for (int k = 0; k < ln && ln <= 16; k++) q.push_back(8'($urandom));
            load(q, -1, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
